sprite_anim_seq: RTL and testbench
==================================

// Module: sprite_anim_seq
// PURPOSE
//  Parametrised character-sprite animation sequencer for the VGA path. It replaces
//  per-frame/per-direction ROM instances with one concatenated sprite ROM.
//  Generates the frame timing, selects frames per action, mirrors for left-facing
//  and pipelines ROM address -> pixel, with a transparency flag for the compositor.
//  Sits between the character state logic and the VGA pixel mux, one instance per character.
// PARAMETERS
//  SPR_W       47        sprite width in pixels
//  SPR_H       64        sprite height in pixels
//  COLOR_W     12        pixel colour width (RGB444)
//  TICK_DIV    6000000   clk cycles per animation tick
//  HOLD_TICKS  4         ticks each frame is held
//  N_STAND     4         stand frames; ROM frame slots 0..N_STAND-1
//  N_RUN       4         run frames; slots N_STAND..N_STAND+N_RUN-1
//  N_JUMP      1         jump frames; following slots
//  ROM_LAT     1         sprite ROM read latency in cycles (>=1)
//  KEY_COLOR   12'h000   colour treated as transparent
// PORTS
//  clk         in   1        system clock
//  rst         in   1        asynchronous reset, active-high
//  char_state  in   3        [0]=dir (1 right, 0 left); [2:1]=00 stand, 01 run, 10 jump, 11 = stand
//  freeze      in   1        pause animation (ticks still counted, frames do not advance)
//  vsync_pls   in   1        one-cycle start-of-video-frame pulse
//  px_x        in   XW       column inside sprite box, XW=$clog2(SPR_W)
//  px_y        in   YW       row inside sprite box, YW=$clog2(SPR_H)
//  px_valid    in   1        px_x/px_y valid this cycle
//  rom_addr    out  AW       sprite ROM address, AW=$clog2(total frames*SPR_W*SPR_H)
//  rom_data    in   COLOR_W  sprite ROM data, ROM_LAT cycles after rom_addr
//  pix_out     out  COLOR_W  pixel colour
//  pix_opaque  out  1        1 = draw pix_out, 0 = background shows through
//  pix_valid   out  1        pix_out/pix_opaque valid
//  frame_idx   out  4        frame slot currently displayed (debug/LED)
// BEHAVIOUR
//  Reset: all counters 0, action latch = stand/right, rom_addr 0, pix_out 0,
//   pix_opaque 0, pix_valid 0, frame_idx 0.
//  Tick: div counter 0..TICK_DIV-1, tick pulse at TICK_DIV-1 then wraps to 0.
//  Hold: on tick and !freeze, hold counter increments. At HOLD_TICKS-1 it wraps and
//   the step index advances mod N of the current action. When N_JUMP=1 the jump frame is held.
//  Action change: when char_state[2:1] differs from its registered copy, step and hold
//   reset to 0 in the next cycle. This takes priority over a coincident tick.
//   A dir-only change does not restart.
//  Tear-free: frame slot = action base + step, computed continuously. It is applied to
//   the display (disp_slot, disp_dir, frame_idx) only on vsync_pls. Simultaneous
//   vsync_pls and advance: the pre-advance value is applied.
//  Pipeline (px_valid at cycle t):
//   t+1: rom_addr = disp_slot*SPR_W*SPR_H + px_y*SPR_W + xm.
//        xm = disp_dir ? px_x : SPR_W-1-px_x.
//        in_range = px_x<SPR_W && px_y<SPR_H; if !in_range, rom_addr holds its value.
//   t+1+ROM_LAT: rom_data sampled.
//   t+2+ROM_LAT: pix_valid=1; pix_out=rom_data.
//        pix_opaque = in_range && rom_data!=KEY_COLOR. When !in_range, pix_out=0.
//  valid/in_range travel in a (ROM_LAT+2)-deep shift register. Fully pipelined:
//   one pixel per cycle, no stalls.
//  Arithmetic: address products use AW-bit unsigned with no truncation before the
//   final add. Reset mid-stream clears all pipeline valids immediately.
// STRUCTURE
//  Package sprite_pkg: ACT_STAND/ACT_RUN/ACT_JUMP encodings, char_state field positions,
//   function for action base slot.
//  Sub-module anim_tick_div (TICK_DIV, HOLD_TICKS): div + hold counters, freeze,
//   restart input, outputs the advance pulse.
//  The top level holds the action latch, step counter, vsync latch and address/pixel pipeline.
// TESTING (bench: TICK_DIV=4, HOLD_TICKS=2, ROM model with data = address[11:0])
//  1 rst pulse mid-stream -> all outputs 0 at once; pix_valid 0 until new px_valid+3.
//  2 stand/right, vsync every 10 clk -> frame_idx 0,1,2,3,0; changes only on vsync cycles.
//  3 px_x=0,px_y=0, dir=1, slot 5 -> rom_addr=5*3008=15040; pix_valid exactly 3 clk later.
//  4 dir=0, px_x=0 -> xm=46; px_x=47 -> pix_opaque=0, pix_out=0.
//  5 run step 2, switch to jump on a tick cycle -> step=0; held at slot 8 with freeze=0.
//  6 freeze=1 for 20 clk -> frame_idx constant; ROM word=KEY_COLOR -> pix_opaque=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared encodings and frame-slot helpers for the sprite animation sequencer.
// Frame slots are laid out stand, run, jump back to back in one concatenated ROM.
package sprite_pkg;

   typedef enum logic [1:0] {
      ACT_STAND     = 2'b00,
      ACT_RUN       = 2'b01,
      ACT_JUMP      = 2'b10,
      ACT_STAND_ALT = 2'b11
   } act_e;

   localparam int CS_DIR     = 0;
   localparam int CS_ACT_LSB = 1;
   localparam int CS_ACT_MSB = 2;

   function automatic logic [3:0] act_base(act_e a, int n_stand, int n_run);
      case (a)
         ACT_RUN:  return 4'(n_stand);
         ACT_JUMP: return 4'(n_stand + n_run);
         default:  return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] act_len(act_e a, int n_stand, int n_run, int n_jump);
      case (a)
         ACT_RUN:  return 4'(n_run);
         ACT_JUMP: return 4'(n_jump);
         default:  return 4'(n_stand);
      endcase
   endfunction

endpackage

// File: rtl/anim_tick_div.sv
// Animation tick divider and per-frame hold counter; pulses advance when a frame's
// hold time expires. Restart clears the hold count and suppresses a coincident advance.
module anim_tick_div #(
   parameter int TICK_DIV   = 6000000,
   parameter int HOLD_TICKS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic freeze,
   input  logic restart,
   output logic advance
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   logic [DW-1:0] div_cnt;
   logic [HW-1:0] hold_cnt;
   logic          tick;
   logic          hold_last;

   assign tick      = (div_cnt == DW'(TICK_DIV - 1));
   assign hold_last = (hold_cnt == HW'(HOLD_TICKS - 1));
   assign advance   = tick && !freeze && hold_last && !restart;

   // Divider runs regardless of freeze so the tick phase stays stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt  <= '0;
         hold_cnt <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (restart)
            hold_cnt <= '0;
         else if (tick && !freeze)
            hold_cnt <= hold_last ? '0 : hold_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sprite_anim_seq.sv
// Character sprite sequencer: action latch, frame step, vsync-latched display slot,
// and the mirrored ROM address -> pixel pipeline with transparency flag.
module sprite_anim_seq
   import sprite_pkg::*;
#(
   parameter int                 SPR_W      = 47,
   parameter int                 SPR_H      = 64,
   parameter int                 COLOR_W    = 12,
   parameter int                 TICK_DIV   = 6000000,
   parameter int                 HOLD_TICKS = 4,
   parameter int                 N_STAND    = 4,
   parameter int                 N_RUN      = 4,
   parameter int                 N_JUMP     = 1,
   parameter int                 ROM_LAT    = 1,
   parameter logic [COLOR_W-1:0] KEY_COLOR  = '0,
   localparam int XW       = $clog2(SPR_W),
   localparam int YW       = $clog2(SPR_H),
   localparam int FRAME_PX = SPR_W * SPR_H,
   localparam int AW       = $clog2((N_STAND + N_RUN + N_JUMP) * FRAME_PX)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         char_state,
   input  logic               freeze,
   input  logic               vsync_pls,
   input  logic [XW-1:0]      px_x,
   input  logic [YW-1:0]      px_y,
   input  logic               px_valid,
   output logic [AW-1:0]      rom_addr,
   input  logic [COLOR_W-1:0] rom_data,
   output logic [COLOR_W-1:0] pix_out,
   output logic               pix_opaque,
   output logic               pix_valid,
   output logic [3:0]         frame_idx
);

   localparam int STAGES = ROM_LAT + 1;

   logic [1:0]    act_q;
   logic          dir_q;
   logic [3:0]    step_q;
   logic [3:0]    disp_slot;
   logic          disp_dir;
   act_e          act_cur;
   logic [3:0]    step_len;
   logic [3:0]    cur_slot;
   logic          restart;
   logic          advance;
   logic          in_range;
   logic [XW-1:0] xm;
   logic [AW-1:0] addr_nxt;
   logic [STAGES:0] vld_pipe;
   logic [STAGES:0] rng_pipe;

   assign act_cur  = act_e'(act_q);
   assign restart  = (char_state[CS_ACT_MSB:CS_ACT_LSB] != act_q);
   assign step_len = act_len(act_cur, N_STAND, N_RUN, N_JUMP);
   assign cur_slot = act_base(act_cur, N_STAND, N_RUN) + step_q;

   anim_tick_div #(
      .TICK_DIV   (TICK_DIV),
      .HOLD_TICKS (HOLD_TICKS)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .freeze  (freeze),
      .restart (restart),
      .advance (advance)
   );

   // Display slot only moves on vsync so a frame never tears mid-scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_q     <= ACT_STAND;
         dir_q     <= 1'b1;
         step_q    <= '0;
         disp_slot <= '0;
         disp_dir  <= 1'b1;
      end else begin
         act_q <= char_state[CS_ACT_MSB:CS_ACT_LSB];
         dir_q <= char_state[CS_DIR];
         if (restart)
            step_q <= '0;
         else if (advance)
            step_q <= (step_q == step_len - 4'd1) ? 4'd0 : step_q + 4'd1;
         if (vsync_pls) begin
            disp_slot <= cur_slot;
            disp_dir  <= dir_q;
         end
      end
   end

   assign frame_idx = disp_slot;

   assign in_range = (32'(px_x) < 32'(SPR_W)) && (32'(px_y) < 32'(SPR_H));
   assign xm       = disp_dir ? px_x : XW'(SPR_W - 1) - px_x;
   assign addr_nxt = AW'(disp_slot) * AW'(FRAME_PX) + AW'(px_y) * AW'(SPR_W) + AW'(xm);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr   <= '0;
         vld_pipe   <= '0;
         rng_pipe   <= '0;
         pix_out    <= '0;
         pix_opaque <= 1'b0;
      end else begin
         if (px_valid && in_range)
            rom_addr <= addr_nxt;
         vld_pipe <= {vld_pipe[STAGES-1:0], px_valid};
         rng_pipe <= {rng_pipe[STAGES-1:0], px_valid && in_range};
         // rom_data belongs to the pixel sitting at stage ROM_LAT this cycle.
         if (vld_pipe[ROM_LAT]) begin
            pix_out    <= rng_pipe[ROM_LAT] ? rom_data : '0;
            pix_opaque <= rng_pipe[ROM_LAT] && (rom_data != KEY_COLOR);
         end
      end
   end

   assign pix_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Randomised and directed bench for sprite_anim_seq against a frame/pixel reference model.
module tb_sprite_anim_seq;

   localparam int TD = 4;
   localparam int HT = 2;
   localparam int W  = 47;
   localparam int H  = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  char_state = 3'b001;
   logic        freeze = 1'b0;
   logic        vsync_pls = 1'b0;
   logic [5:0]  px_x = '0;
   logic [5:0]  px_y = '0;
   logic        px_valid = 1'b0;
   logic [14:0] rom_addr;
   logic [11:0] rom_data;
   logic [11:0] pix_out;
   logic        pix_opaque;
   logic        pix_valid;
   logic [3:0]  frame_idx;
   bit          key_mode = 1'b0;

   sprite_anim_seq #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
      .clk(clk), .rst(rst), .char_state(char_state), .freeze(freeze),
      .vsync_pls(vsync_pls), .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
      .rom_addr(rom_addr), .rom_data(rom_data), .pix_out(pix_out),
      .pix_opaque(pix_opaque), .pix_valid(pix_valid), .frame_idx(frame_idx)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_data <= key_mode ? 12'h000 : rom_addr[11:0];

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Reference state: time-based animation counters plus display latch.
   int m_div, m_hold, m_step, m_act, m_dir, m_dslot, m_ddir, m_addr;
   int ecount = 0;
   bit s_v[8];
   int s_pix[8];
   bit s_op[8];

   function automatic int base(int a);
      return (a == 1) ? 4 : (a == 2) ? 8 : 0;
   endfunction

   function automatic int alen(int a);
      return (a == 2) ? 1 : 4;
   endfunction

   task automatic model_reset();
      m_div = 0; m_hold = 0; m_step = 0; m_act = 0; m_dir = 1;
      m_dslot = 0; m_ddir = 1; m_addr = 0;
      for (int i = 0; i < 8; i++) begin s_v[i] = 0; s_pix[i] = 0; s_op[i] = 0; end
   endtask

   task automatic step_cycle();
      int  cur, idx, pix;
      bit  tick, rs, inr;
      if (rst) model_reset();
      else begin
         tick = (m_div == TD - 1);
         rs   = (int'(char_state[2:1]) != m_act);
         cur  = base(m_act) + m_step;
         if (px_valid) begin
            inr = (px_x < W) && (px_y < H);
            if (inr) m_addr = m_dslot * W * H + int'(px_y) * W + (m_ddir ? int'(px_x) : W - 1 - int'(px_x));
            pix = inr ? (key_mode ? 0 : m_addr % 4096) : 0;
            idx = (ecount + 3) % 8;
            s_v[idx] = 1; s_pix[idx] = pix; s_op[idx] = inr && (pix != 0);
         end
         m_div = (m_div + 1) % TD;
         if (rs) begin
            m_hold = 0; m_step = 0;
         end else if (tick && !freeze) begin
            m_hold++;
            if (m_hold == HT) begin m_hold = 0; m_step = (m_step + 1) % alen(m_act); end
         end
         if (vsync_pls) begin m_dslot = cur; m_ddir = m_dir; end
         m_act = int'(char_state[2:1]);
         m_dir = int'(char_state[0]);
      end
      @(posedge clk); #1;
      ecount++;
      idx = ecount % 8;
      chk("frame_idx", int'(frame_idx), m_dslot);
      chk("rom_addr", int'(rom_addr), m_addr);
      chk("pix_valid", int'(pix_valid), int'(s_v[idx]));
      if (s_v[idx]) begin
         chk("pix_out", int'(pix_out), s_pix[idx]);
         chk("pix_opaque", int'(pix_opaque), int'(s_op[idx]));
      end
      s_v[idx] = 0;
   endtask

   task automatic idle(input int n);
      px_valid = 0; vsync_pls = 0;
      for (int i = 0; i < n; i++) step_cycle();
   endtask

   initial begin
      int frozen;
      bit found;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_frame_idx", int'(frame_idx), 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_pix_out", int'(pix_out), 0);
      chk("rst_pix_opaque", int'(pix_opaque), 0);
      chk("rst_pix_valid", int'(pix_valid), 0);
      rst = 0;

      // stand/right, vsync every 10 clk
      char_state = 3'b001;
      for (int i = 0; i < 50; i++) begin
         vsync_pls = (i % 10 == 9);
         step_cycle();
      end

      // run/right: latch slot 5 then probe pixel (0,0)
      char_state = 3'b011; vsync_pls = 0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         vsync_pls = (base(m_act) + m_step == 5);
         found = vsync_pls;
         step_cycle();
      end
      chk("find_slot5", int'(found), 1);
      vsync_pls = 0; px_valid = 1; px_x = 0; px_y = 0;
      step_cycle();
      chk("slot5_addr", int'(rom_addr), 15040);
      px_valid = 0;
      step_cycle();
      step_cycle();
      chk("latency3", int'(pix_valid), 1);

      // left-facing mirror and out-of-range column
      char_state = 3'b010;
      step_cycle();
      vsync_pls = 1;
      step_cycle();
      vsync_pls = 0; px_valid = 1; px_x = 0; px_y = 0;
      step_cycle();
      chk("mirror_x0", int'(rom_addr), m_dslot * W * H + 46);
      px_x = 47;
      step_cycle();
      chk("oor_addr_hold", int'(rom_addr), m_dslot * W * H + 46);
      idle(2);
      chk("oor_opaque", int'(pix_opaque), 0);
      chk("oor_pix", int'(pix_out), 0);

      // run step 2, switch to jump on a tick cycle
      char_state = 3'b011;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         found = (m_act == 1) && (m_step == 2) && (m_div == TD - 1);
         if (found) char_state = 3'b101;
         step_cycle();
      end
      chk("find_run2_tick", int'(found), 1);
      chk("jump_restart", m_step, 0);
      for (int i = 0; i < 40; i++) begin
         vsync_pls = (i % 5 == 0);
         step_cycle();
         if (i > 0) chk("jump_held", int'(frame_idx), 8);
      end

      // freeze holds the frame; key colour makes pixels transparent
      char_state = 3'b001; vsync_pls = 0;
      idle(3);
      vsync_pls = 1;
      step_cycle();
      frozen = base(m_act) + m_step;
      freeze = 1;
      step_cycle();
      for (int i = 0; i < 20; i++) begin
         vsync_pls = (i % 4 == 1);
         step_cycle();
         chk("freeze_hold", int'(frame_idx), frozen);
      end
      freeze = 0; vsync_pls = 0;
      idle(4);
      key_mode = 1;
      for (int i = 0; i < 10; i++) begin
         px_valid = (i < 7); px_x = 6'(i * 5); px_y = 6'(i * 3);
         step_cycle();
         if (i >= 3) chk("key_transp", int'(pix_opaque), 0);
      end
      idle(4);
      key_mode = 0;

      // mid-stream reset
      for (int i = 0; i < 5; i++) begin
         px_valid = 1; px_x = 6'($urandom_range(0, 46)); px_y = 6'($urandom_range(0, 63));
         step_cycle();
      end
      rst = 1;
      #1;
      chk("arst_frame_idx", int'(frame_idx), 0);
      chk("arst_rom_addr", int'(rom_addr), 0);
      chk("arst_pix_out", int'(pix_out), 0);
      chk("arst_pix_opaque", int'(pix_opaque), 0);
      chk("arst_pix_valid", int'(pix_valid), 0);
      model_reset();
      step_cycle();
      step_cycle();
      rst = 0;
      for (int i = 0; i < 6; i++) begin
         px_valid = 1; px_x = 6'($urandom_range(0, 46)); px_y = 6'($urandom_range(0, 63));
         step_cycle();
      end

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) char_state[2:1] = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 19) == 0) char_state[0] = ~char_state[0];
         freeze    = ($urandom_range(0, 9) == 0);
         vsync_pls = ($urandom_range(0, 7) == 0);
         px_valid  = ($urandom_range(0, 3) != 0);
         px_x      = 6'($urandom_range(0, 50));
         px_y      = 6'($urandom_range(0, 63));
         step_cycle();
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
